// File: rtl/drive_pkg.sv
// Shared types and helpers for the differential-drive controller.
package drive_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } drive_state_t;

  // Clamp a signed value into [0, 2^width-1]; callers slice the result down.
  function automatic logic [63:0] sat_unsigned(input logic signed [63:0] x,
                                               input int unsigned width);
    logic signed [63:0] max_v;
    max_v = (64'sd1 <<< width) - 64'sd1;
    if (x < 64'sd0) return '0;
    if (x > max_v) return max_v;
    return x;
  endfunction

  function automatic logic within_step(input logic [63:0] a,
                                       input logic [63:0] b,
                                       input logic [63:0] step);
    return ((a >= b) ? (a - b) : (b - a)) <= step;
  endfunction

endpackage

// File: rtl/slew_limiter.sv
// Per-side duty register that moves toward its target by at most STEP per tick.
module slew_limiter #(
  parameter int WIDTH = 17,
  parameter int STEP  = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             clear,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

  logic [WIDTH:0]   val_x, tgt_x, up_x, dn_x;
  logic [WIDTH-1:0] value_n;

  // One extra bit so neither the step up nor the step down can wrap.
  always_comb begin
    val_x   = {1'b0, value};
    tgt_x   = {1'b0, target};
    up_x    = val_x + STEP_X;
    dn_x    = val_x - STEP_X;
    value_n = value;
    if (tgt_x > val_x) begin
      value_n = (up_x >= tgt_x) ? target : up_x[WIDTH-1:0];
    end else begin
      value_n = (dn_x[WIDTH] || dn_x <= tgt_x) ? target : dn_x[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      value <= '0;
    end else if (clk_en) begin
      value <= value_n;
    end
  end

endmodule

// File: rtl/diff_drive_ctrl.sv
// Differential-drive controller: offset clamp, saturated targets, slew-limited
// duties and the run/stop sequencing FSM.
//
// state     | meaning
// IDLE      | motors off, duties held at 0
// RAMP_UP   | soft start toward run targets
// RUN       | tracking run targets, PID enabled
// RAMP_DOWN | soft stop toward 0
module diff_drive_ctrl
  import drive_pkg::*;
#(
  parameter int PWM_RESOLUTION = 17,
  parameter int CTRL_WIDTH     = 18,
  parameter int BASE_DUTY      = 16384,
  parameter int MAX_OFFSET     = 8192,
  parameter int SLEW_STEP      = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_en,
  input  logic                         toggle_req,
  input  logic                         estop,
  input  logic signed [CTRL_WIDTH-1:0] ctrl_in,
  output logic [PWM_RESOLUTION-1:0]    duty_l,
  output logic [PWM_RESOLUTION-1:0]    duty_r,
  output logic                         motor_en,
  output logic                         pid_en,
  output logic [1:0]                   state_o,
  output logic                         at_target
);

  localparam int EW = PWM_RESOLUTION + 2;
  localparam logic signed [CTRL_WIDTH-1:0] OFF_HI = CTRL_WIDTH'(MAX_OFFSET);
  localparam logic signed [CTRL_WIDTH-1:0] OFF_LO = -OFF_HI;
  localparam logic signed [EW-1:0]         BASE_X = EW'(BASE_DUTY);
  localparam logic [63:0]                  STEP_W = 64'(SLEW_STEP);

  drive_state_t state, state_n;

  logic signed [CTRL_WIDTH-1:0] off;
  logic signed [EW-1:0]         off_x, sum_l, sum_r;
  logic [PWM_RESOLUTION-1:0]    run_l, run_r, tgt_l, tgt_r;
  logic                         run_near, stop_near, at_next;

  always_comb begin
    off   = (ctrl_in > OFF_HI) ? OFF_HI : (ctrl_in < OFF_LO) ? OFF_LO : ctrl_in;
    off_x = EW'(off);
    sum_r = BASE_X + off_x;
    sum_l = BASE_X - off_x;
    run_r = PWM_RESOLUTION'(sat_unsigned(64'(sum_r), PWM_RESOLUTION));
    run_l = PWM_RESOLUTION'(sat_unsigned(64'(sum_l), PWM_RESOLUTION));
  end

  // Equivalent to "post-update duty equals target" on a tick.
  assign run_near  = within_step(64'(duty_l), 64'(run_l), STEP_W) &&
                     within_step(64'(duty_r), 64'(run_r), STEP_W);
  assign stop_near = (64'(duty_l) <= STEP_W) && (64'(duty_r) <= STEP_W);

  always_comb begin
    state_n = state;
    if (estop) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:      if (toggle_req) state_n = RAMP_UP;
        RAMP_UP:   if (toggle_req) state_n = RAMP_DOWN;
                   else if (clk_en && run_near) state_n = RUN;
        RUN:       if (toggle_req) state_n = RAMP_DOWN;
        RAMP_DOWN: if (toggle_req) state_n = RAMP_UP;
                   else if (clk_en && stop_near) state_n = IDLE;
        default:   state_n = IDLE;
      endcase
    end
  end

  // Targets follow the next state so a coincident tick already slews toward them.
  always_comb begin
    tgt_l = '0;
    tgt_r = '0;
    if (state_n == RAMP_UP || state_n == RUN) begin
      tgt_l = run_l;
      tgt_r = run_r;
    end
    if (estop) begin
      at_next = 1'b1;
    end else if (clk_en) begin
      at_next = within_step(64'(duty_l), 64'(tgt_l), STEP_W) &&
                within_step(64'(duty_r), 64'(tgt_r), STEP_W);
    end else begin
      at_next = (duty_l == tgt_l) && (duty_r == tgt_r);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      motor_en  <= 1'b0;
      pid_en    <= 1'b0;
      at_target <= 1'b1;
    end else begin
      state     <= state_n;
      motor_en  <= (state_n != IDLE);
      pid_en    <= (state_n == RUN);
      at_target <= at_next;
    end
  end

  assign state_o = state;

  slew_limiter #(.WIDTH(PWM_RESOLUTION), .STEP(SLEW_STEP)) u_slew_l (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .clear  (estop),
    .target (tgt_l),
    .value  (duty_l)
  );

  slew_limiter #(.WIDTH(PWM_RESOLUTION), .STEP(SLEW_STEP)) u_slew_r (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .clear  (estop),
    .target (tgt_r),
    .value  (duty_r)
  );

endmodule
